tone_detector: RTL
==================

# tone_detector

Receive-side counterpart of the sidetone generator. Samples a square-wave audio input, typically a comparator output from a receiver, on the 50 MHz system clock. It measures each half-period, locks when a run of half-periods falls inside the 600 Hz window, and times the key-down interval in half-periods. When the tone drops, it emits a one-cycle `dit` or `dah` pulse for the downstream Morse decoder.

## Interface
- `MIN_HALF`, 16'h9C40 (40000): minimum accepted half-period in clock cycles (about 625 Hz).
- `MAX_HALF`, 16'hA945 (43333): maximum accepted half-period in clock cycles (about 577 Hz); nominal is 16'hA2C2.
- `LOCK_EDGES`, 4: consecutive valid half-periods required to declare the tone present.
- `DAH_HALVES`, 10'd144: key-down length in half-periods at or above which a symbol is a dah (120 ms at 600 Hz).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `tone_in`  in  1  asynchronous square-wave input.
- `tone_present`  out  1  high while locked to a valid tone.
- `dit`  out  1  one-cycle pulse: a short symbol ended.
- `dah`  out  1  one-cycle pulse: a long symbol ended.

## Operation
- **Input conditioning:** `tone_in` passes through a 2-flop synchronizer, then a third flop for edge detection. Any change between the last two stages is an edge; rising and falling edges both count.
- **Half-period counter (16-bit):** increments every cycle and saturates at 16'hFFFF. On an edge, the current value is evaluated and the counter loads 1.
  - An edge is valid iff MIN_HALF <= count <= MAX_HALF.
- **Reset values:** counter saturated (16'hFFFF). Because the counter starts saturated, the first edge after reset or idle is always invalid and only starts timing.
- **Symbol counter (10-bit):** counts half-periods and saturates at 10'h3FF.
- **State machine:** three states: IDLE, ACQUIRE, LOCKED.
  - IDLE: on any edge, go to ACQUIRE with valid-run count 0.
  - ACQUIRE, valid edge: increment the run count. When it reaches LOCK_EDGES, go to LOCKED, set `tone_present`, and load the symbol counter with LOCK_EDGES.
  - ACQUIRE, invalid edge: clear the run count and stay in ACQUIRE.
  - ACQUIRE, no edge: when the counter exceeds MAX_HALF, return to IDLE and clear the run count. No pulse.
  - LOCKED, valid edge: increment the symbol counter.
  - LOCKED, lock loss: an invalid edge, or the counter reaching MAX_HALF+1 with no edge. Clear `tone_present`, go to IDLE, and pulse exactly one of:
    - `dit` if symbol count < DAH_HALVES;
    - `dah` otherwise.
  - After an invalid-edge loss, that edge does not seed a new acquisition. Reacquisition starts from the next edge, via IDLE.
- `dit` and `dah` are never high together and are never asserted outside a LOCKED-to-IDLE transition.
- **Reset:** `rst` at any time, including mid-symbol, forces IDLE and clears all counters except the half-period counter, which goes to 16'hFFFF. It drives `tone_present`, `dit` and `dah` low in the following cycle and suppresses the pending symbol pulse.

## Timing
- All outputs are registered. Reset value of `tone_present`, `dit` and `dah` is 0.
- Pin-to-edge latency is 3 cycles (two synchronizer stages plus the edge-detect stage).
- Lock: `tone_present` rises on the clock after the edge cycle that completes the LOCK_EDGES-th valid half-period.
- Timeout loss: the loss is detected in the cycle the counter equals MAX_HALF+1. `tone_present` falls and `dit`/`dah` rises on the next clock. The pulse lasts exactly 1 cycle.
- Invalid-edge loss: same timing, referenced to the edge cycle.
- An edge arriving in the same cycle the counter equals MAX_HALF+1 is treated as an invalid edge. The result is one loss event only.
- Symbol counter saturation at 10'h3FF still yields `dah`.

## Test plan
Benches override the parameters to MIN_HALF=8, MAX_HALF=12, LOCK_EDGES=4, DAH_HALVES=20, giving a nominal half-period of 10 cycles.
1. Reset: assert `rst` 3 cycles with `tone_in` toggling -> `tone_present`, `dit` and `dah` are 0 throughout and in the first cycle after release.
2. 12 half-periods of 10 cycles, then hold `tone_in` -> `tone_present` rises 1 cycle after the 5th edge (4 valid halves). It falls 13 cycles after the last edge. `dit` is a 1-cycle pulse aligned with the fall, and `dah` stays 0.
3. 30 half-periods of 10 cycles -> lock as in scenario 2, then a single 1-cycle `dah` pulse at the fall; `dit` stays 0.
4. Half-periods of 5 cycles, then 15 cycles, repeated for 40 edges -> `tone_present`, `dit` and `dah` stay 0.
5. Lock, then 6 valid halves, then one 6-cycle half -> `dit` pulse 1 cycle after the bad edge. Then 10-cycle halves -> relock needs the next edge plus 4 valid halves.
6. Lock, then assert `rst` mid-symbol -> `tone_present` falls the next cycle, with no `dit` or `dah` pulse at that time or afterwards while `tone_in` stays idle.

Source files
------------

// File: rtl/tone_detector.sv
// Receive-side tone detector: locks onto a square-wave input whose half-periods
// fall inside [MIN_HALF, MAX_HALF] and reports each keyed symbol as a dit or dah pulse.
module tone_detector #(
  parameter logic [15:0] MIN_HALF   = 16'h9C40,
  parameter logic [15:0] MAX_HALF   = 16'hA945,
  parameter int unsigned LOCK_EDGES = 4,
  parameter logic [9:0]  DAH_HALVES = 10'd144
) (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic tone_present,
  output logic dit,
  output logic dah
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic [15:0] TIMEOUT  = MAX_HALF + 16'd1;
  localparam logic [7:0]  RUN_LAST = 8'(LOCK_EDGES - 1);
  localparam logic [9:0]  SYM_LOAD = 10'(LOCK_EDGES);

  state_t      state;
  logic [2:0]  sync;
  logic [15:0] half_cnt;
  logic [7:0]  run;
  logic [9:0]  sym;

  logic edge_seen;
  logic edge_valid;
  logic timeout;

  // sync[1:0] is the synchronizer, sync[2] the edge-detect stage
  assign edge_seen  = sync[2] ^ sync[1];
  assign edge_valid = edge_seen && (half_cnt >= MIN_HALF) && (half_cnt <= MAX_HALF);
  assign timeout    = (half_cnt == TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync         <= '0;
      half_cnt     <= '1;
      run          <= '0;
      sym          <= '0;
      tone_present <= 1'b0;
      dit          <= 1'b0;
      dah          <= 1'b0;
    end else begin
      sync <= {sync[1:0], tone_in};
      dit  <= 1'b0;
      dah  <= 1'b0;

      if (edge_seen) begin
        half_cnt <= 16'd1;
      end else if (half_cnt != '1) begin
        half_cnt <= half_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (edge_seen) begin
            state <= ACQUIRE;
            run   <= '0;
          end
        end

        ACQUIRE: begin
          if (edge_seen) begin
            if (edge_valid) begin
              if (run == RUN_LAST) begin
                state        <= LOCKED;
                tone_present <= 1'b1;
                sym          <= SYM_LOAD;
                run          <= '0;
              end else begin
                run <= run + 8'd1;
              end
            end else begin
              run <= '0;
            end
          end else if (half_cnt > MAX_HALF) begin
            state <= IDLE;
            run   <= '0;
          end
        end

        LOCKED: begin
          if (edge_valid) begin
            if (sym != '1) begin
              sym <= sym + 10'd1;
            end
          end else if (edge_seen || timeout) begin
            // an edge coinciding with the timeout is invalid, so this is one loss
            state        <= IDLE;
            tone_present <= 1'b0;
            if (sym < DAH_HALVES) begin
              dit <= 1'b1;
            end else begin
              dah <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          run   <= '0;
        end
      endcase
    end
  end

endmodule
